dmem_bus_ctrl: RTL and testbench

Data-memory port controller sitting directly downstream of the multicycle control-unit FSM. It turns the FSM's one-cycle load/store strobes (mem_RDEN2, mem_WE2) into a held request/acknowledge transaction on a variable-latency data bus. It applies RISC-V byte/half/word lane alignment, byte enables, and load sign/zero extension. It returns a stall (busy), a completion pulse (done) and an error flag, so the FSM can hold in EXECUTE/WRITEBACK until memory answers.

---
 rtl/dmem_bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Turns one-cycle load/store strobes into a held req/ack data
//               bus transaction with lane alignment and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_RDEN2,
  input  logic        mem_WE2,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_unsigned;

  logic          w_req;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign w_req = mem_RDEN2 | mem_WE2;

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = mem_din;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_din[7:0]}};
      end
      2'b01: begin
        w_misalign = mem_addr[0];
        w_be       = 4'b0011 << {mem_addr[1], 1'b0};
        w_wdata    = {2{mem_din[15:0]}};
      end
      2'b10:   w_misalign = |mem_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Lane selection uses the offset/size captured at acceptance, not live inputs.
  assign w_byte = bus_rdata[{r_off, 3'b000} +: 8];
  assign w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wdata  <= 32'h0;
      mem_dout   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (w_req) begin
            if (w_misalign) begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
            end else begin
              r_state    <= S_WAIT;
              r_cnt      <= '0;
              r_off      <= mem_addr[1:0];
              r_size     <= mem_size;
              r_unsigned <= mem_unsigned;
              bus_we     <= mem_WE2;
              bus_addr   <= {mem_addr[31:2], 2'b00};
              bus_be     <= w_be;
              bus_wdata  <= w_wdata;
            end
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            r_state <= S_RESP;
            r_err   <= 1'b0;
            if (!bus_we) mem_dout <= w_load;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= S_RESP;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req = (r_state == S_WAIT);
  assign done    = (r_state == S_RESP);
  assign err     = r_err;
  assign busy    = (r_state == S_WAIT) | ((r_state == S_IDLE) & w_req);

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Randomized bench for dmem_bus_ctrl against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_RDEN2, mem_WE2, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        busy, done, err, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_dout = 32'h0;

  dmem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_RDEN2(mem_RDEN2), .mem_WE2(mem_WE2), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic txn(input bit rd, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] rdata, input int ack_at, input bit noise);
    bit          legal;
    bit          acked;
    int          off;
    int          n;
    logic [3:0]  be;
    logic [31:0] wd, ld, lane;
    off   = int'(addr[1:0]);
    legal = (sz == 2'd0) || (sz == 2'd1 && addr[0] == 1'b0) || (sz == 2'd2 && addr[1:0] == 2'b00);
    case (sz)
      2'd0:    begin be = 4'(1 << off); wd = {4{din[7:0]}}; end
      2'd1:    begin be = 4'(3 << off); wd = {2{din[15:0]}}; end
      default: begin be = 4'hF;         wd = din; end
    endcase
    lane = rdata >> (8 * off);
    case (sz)
      2'd0: begin
        ld = lane & 32'hFF;
        if (!uns && lane[7]) ld = ld | 32'hFFFF_FF00;
      end
      2'd1: begin
        ld = lane & 32'hFFFF;
        if (!uns && lane[15]) ld = ld | 32'hFFFF_0000;
      end
      default: ld = rdata;
    endcase

    mem_RDEN2 = rd; mem_WE2 = we; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_din = din;
    #1 check("busy_on_strobe", {31'b0, busy}, 32'd1);
    @(negedge clk);
    mem_RDEN2 = 1'b0; mem_WE2 = 1'b0;

    if (!legal) begin
      check("bad_done", {31'b0, done}, 32'd1);
      check("bad_err", {31'b0, err}, 32'd1);
      check("bad_no_req", {31'b0, bus_req}, 32'd0);
      check("bad_busy", {31'b0, busy}, 32'd0);
      check("bad_dout", mem_dout, model_dout);
    end else begin
      check("bus_we", {31'b0, bus_we}, {31'b0, we});
      check("bus_addr", bus_addr, {addr[31:2], 2'b00});
      check("bus_be", {28'b0, bus_be}, {28'b0, be});
      check("bus_wdata", bus_wdata, wd);
      n = 0;
      acked = 1'b0;
      for (int i = 0; i < TO; i++) begin
        if (bus_req && busy) n++;
        if (noise) begin
          mem_RDEN2 = 1'($urandom); mem_WE2 = 1'($urandom);
          mem_addr = $urandom; mem_size = 2'($urandom); mem_din = $urandom;
        end
        bus_ack   = (i == ack_at);
        bus_rdata = (i == ack_at) ? rdata : $urandom;
        @(negedge clk);
        mem_RDEN2 = 1'b0; mem_WE2 = 1'b0;
        bus_ack = 1'b0;
        if (i == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      if (acked && !we) model_dout = ld;
      check("req_cycles", n, acked ? ack_at + 1 : TO);
      check("resp_done", {31'b0, done}, 32'd1);
      check("resp_err", {31'b0, err}, {31'b0, !acked});
      check("resp_req", {31'b0, bus_req}, 32'd0);
      check("resp_busy", {31'b0, busy}, 32'd0);
      check("resp_dout", mem_dout, model_dout);
    end
    @(negedge clk);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_err", {31'b0, err}, 32'd0);
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus_ack = 1'($urandom);
      bus_rdata = $urandom;
      @(negedge clk);
      check("gap_req", {31'b0, bus_req}, 32'd0);
      check("gap_done", {31'b0, done}, 32'd0);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_RDEN2 = 0; mem_WE2 = 0; mem_size = 0; mem_unsigned = 0;
    mem_addr = 0; mem_din = 0; bus_rdata = 0; bus_ack = 0;
    @(negedge clk);
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_be", {28'b0, bus_be}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_dout", mem_dout, 32'd0);
    check("rst_done", {30'b0, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
    check("word_load_val", mem_dout, 32'hDEADBEEF);
    txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
    check("byte_signed_val", mem_dout, 32'hFFFF_FF80);
    txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    check("byte_unsigned_val", mem_dout, 32'h0000_0080);
    txn(0, 1, 2'd1, 0, 32'h22, 32'h1234ABCD, 32'h0, 0, 1);
    check("half_store_keep", mem_dout, 32'h0000_0080);
    txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 2'd1, 0, 32'h200, 32'h0, 32'h0, 99, 0);

    // Reset during the second WAIT cycle.
    mem_RDEN2 = 1; mem_size = 2'd2; mem_addr = 32'h40;
    @(negedge clk);
    mem_RDEN2 = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req", {31'b0, bus_req}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_dout", mem_dout, 32'd0);
    model_dout = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1, 1, 2'd2, 0, 32'h80, 32'hCAFEF00D, 32'h11111111, 1, 0);
    check("both_is_store", mem_dout, 32'h0);

    for (int k = 0; k < 60; k++) begin
      bit r, w;
      r = 1'($urandom);
      w = r ? 1'($urandom) : 1'b1;
      txn(r, w, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          $urandom_range(0, TO + 1), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
